wave_display_multi: RTL and testbench

Parametrised multi-channel successor to the single-trace waveform renderer. It sits between the VGA/DVI timing generator and a double-buffered sample RAM. Per pixel, it fetches one sample word per channel, interpolates a vertical segment from the previous column's sample to the current one, and emits a registered RGB pixel. It owns the display/write buffer select and swaps it with the sample producer through a frame-synchronous req/ack handshake.

---
 rtl/wave_pkg.sv | 30 +++
 rtl/wave_channel_hit.sv | 46 ++++
 rtl/wave_display_multi.sv | 167 ++++++++++++++++
 tb/tb_wave_display_multi.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// wave_pkg: shared colour constants, RGB type and swap-FSM state encoding
// for the multi-channel waveform renderer.
`default_nettype none

package wave_pkg;

  typedef logic [23:0] rgb_t;

  localparam rgb_t C_BLACK = 24'h000000;
  localparam rgb_t C_WHITE = 24'hFFFFFF;
  localparam rgb_t C_RED   = 24'hFF0000;
  localparam rgb_t C_GREEN = 24'h00FF00;
  localparam rgb_t C_SKY   = 24'h00A0FF;

  // Channel c lives at [c*24 +: 24], so channel 0 (white) is the LSB slot.
  localparam logic [95:0] DEF_CH_COLORS = {C_SKY, C_GREEN, C_RED, C_WHITE};
  localparam rgb_t        DEF_BG_COLOR  = C_BLACK;

  typedef enum logic [0:0] {
    SW_IDLE = 1'b0,
    SW_ACK  = 1'b1
  } swap_state_t;

  function automatic rgb_t ch_color(input logic [95:0] tab, input int c);
    return tab[c*24 +: 24];
  endfunction

endpackage

`default_nettype wire

// File: rtl/wave_channel_hit.sv
// wave_channel_hit: per-channel previous-column sample tracking and the
// inclusive vertical-segment range test for one trace.
`default_nettype none

module wave_channel_hit #(
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic                i_upd,
  input  logic                i_first,
  input  logic                i_col_change,
  input  logic [SAMPLE_W-1:0] i_cur,
  input  logic [SAMPLE_W-1:0] i_ty,
  output logic                o_hit
);

  logic [SAMPLE_W-1:0] r_prev;
  logic [SAMPLE_W-1:0] r_seen;
  logic [SAMPLE_W-1:0] w_prev_src;
  logic [SAMPLE_W-1:0] w_prev;
  logic [SAMPLE_W-1:0] w_lo;
  logic [SAMPLE_W-1:0] w_hi;

  // r_seen is the sample of the column being drawn; on a column change it
  // becomes the "previous" sample for both pixels of the new column.
  assign w_prev_src = i_col_change ? r_seen : r_prev;
  assign w_prev     = i_first ? i_cur : w_prev_src;
  assign w_lo       = (w_prev < i_cur) ? w_prev : i_cur;
  assign w_hi       = (w_prev < i_cur) ? i_cur : w_prev;
  assign o_hit      = i_en && (i_ty >= w_lo) && (i_ty <= w_hi);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
      r_seen <= '0;
    end else if (i_upd) begin
      r_prev <= w_prev;
      r_seen <= i_cur;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wave_display_multi.sv
// wave_display_multi: multi-channel waveform renderer with 2-cycle pixel
// pipeline and frame-synchronous double-buffer swap handshake.
`default_nettype none

module wave_display_multi
  import wave_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          SAMPLE_W  = 8,
  parameter int          ADDR_W    = 8,
  parameter int          X_W       = 11,
  parameter int          Y_W       = 10,
  parameter int          WIN_X0    = 256,
  parameter logic [95:0] CH_COLORS = DEF_CH_COLORS,
  parameter rgb_t        BG_COLOR  = DEF_BG_COLOR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [X_W-1:0]             x,
  input  logic [Y_W-1:0]             y,
  input  logic                       valid,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic                       swap_req,
  output logic                       swap_ack,
  output logic                       buf_sel,
  output logic [ADDR_W:0]            read_address,
  input  logic [NUM_CH*SAMPLE_W-1:0] read_value,
  output logic                       valid_pixel,
  output logic [7:0]                 r,
  output logic [7:0]                 g,
  output logic [7:0]                 b
);

  localparam int unsigned C_X_LO = WIN_X0;
  localparam int unsigned C_X_HI = WIN_X0 + 2**(ADDR_W+1);
  localparam int unsigned C_Y_HI = 2**(SAMPLE_W+1);

  // Stage 0: window decode and sample address.
  logic [X_W-1:0]      w_xoff;
  logic [ADDR_W-1:0]   w_col0;
  logic [SAMPLE_W-1:0] w_ty0;
  logic                w_in_win0;
  logic                w_frame_start;
  logic [ADDR_W-1:0]   r_col_hold;
  logic                r_buf_sel;

  assign w_xoff        = x - X_W'(WIN_X0);
  assign w_col0        = ADDR_W'(w_xoff >> 1);
  assign w_ty0         = y[SAMPLE_W:1];
  assign w_in_win0     = valid && (32'(x) >= C_X_LO) && (32'(x) < C_X_HI)
                         && (32'(y) < C_Y_HI);
  assign w_frame_start = valid && (x == '0) && (y == '0);
  assign read_address  = {r_buf_sel, (w_in_win0 ? w_col0 : r_col_hold)};
  assign buf_sel       = r_buf_sel;

  // Stage 1: sample data arrives; x/y-derived state delayed to match.
  logic                r_s1_inwin;
  logic                r_s1_first;
  logic [ADDR_W-1:0]   r_s1_col;
  logic [SAMPLE_W-1:0] r_s1_ty;
  logic [ADDR_W-1:0]   r_last_col;
  logic                w_col_change;
  logic [NUM_CH-1:0]   w_hit;
  rgb_t                w_rgb;

  assign w_col_change = (r_s1_col != r_last_col);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_inwin <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_col   <= '0;
      r_s1_ty    <= '0;
      r_col_hold <= '0;
      r_last_col <= '0;
    end else begin
      r_s1_inwin <= w_in_win0;
      r_s1_first <= (x == X_W'(WIN_X0));
      r_s1_col   <= w_col0;
      r_s1_ty    <= w_ty0;
      if (w_in_win0) r_col_hold <= w_col0;
      if (r_s1_inwin) r_last_col <= r_s1_col;
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      wave_channel_hit #(
        .SAMPLE_W (SAMPLE_W)
      ) u_hit (
        .clk          (clk),
        .reset        (reset),
        .i_en         (ch_enable[c]),
        .i_upd        (r_s1_inwin),
        .i_first      (r_s1_first),
        .i_col_change (w_col_change),
        .i_cur        (read_value[c*SAMPLE_W +: SAMPLE_W]),
        .i_ty         (r_s1_ty),
        .o_hit        (w_hit[c])
      );
    end
  endgenerate

  // Walk from the highest index down so the lowest hitting channel wins.
  always_comb begin
    w_rgb = BG_COLOR;
    if (r_s1_inwin) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (w_hit[c]) w_rgb = ch_color(CH_COLORS, c);
      end
    end
  end

  // Stage 2: registered pixel.
  rgb_t r_rgb;
  logic r_vp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb <= '0;
      r_vp  <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      r_vp  <= r_s1_inwin;
    end
  end

  assign r           = r_rgb[23:16];
  assign g           = r_rgb[15:8];
  assign b           = r_rgb[7:0];
  assign valid_pixel = r_vp;

  // Swap handshake: buffer flips only at frame start, so a frame never tears.
  swap_state_t r_state;
  swap_state_t w_state_nxt;
  logic        w_swap_go;

  always_comb begin
    w_state_nxt = r_state;
    w_swap_go   = 1'b0;
    case (r_state)
      SW_IDLE: begin
        if (w_frame_start && swap_req) begin
          w_state_nxt = SW_ACK;
          w_swap_go   = 1'b1;
        end
      end
      SW_ACK:  w_state_nxt = SW_IDLE;
      default: w_state_nxt = SW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= SW_IDLE;
      r_buf_sel <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_swap_go) r_buf_sel <= ~r_buf_sel;
    end
  end

  assign swap_ack = (r_state == SW_ACK);

endmodule

`default_nettype wire

// File: tb/tb_wave_display_multi.sv
// tb_wave_display_multi: randomized scan of several frames against a
// column-level reference model, with swap handshake and mid-row reset.
`default_nettype none

module tb_wave_display_multi;

  localparam int NCH  = 3;
  localparam int SW   = 4;
  localparam int AW   = 4;
  localparam int XW   = 11;
  localparam int YW   = 10;
  localparam int WX0  = 8;
  localparam int NCOL = 16;
  localparam int WINW = 32;
  localparam int WINH = 32;
  localparam int FW   = 44;
  localparam int FH   = 36;
  localparam int VW   = 42;
  localparam int VH   = 34;
  localparam int NFR  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              valid;
  logic [NCH-1:0]    ch_enable;
  logic              swap_req;
  logic              swap_ack;
  logic              buf_sel;
  logic [AW:0]       read_address;
  logic [NCH*SW-1:0] read_value;
  logic              valid_pixel;
  logic [7:0]        r, g, b;

  int          mem [2][NCH][NCOL];
  logic [23:0] col_tab [NCH];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  wave_display_multi #(
    .NUM_CH   (NCH),
    .SAMPLE_W (SW),
    .ADDR_W   (AW),
    .X_W      (XW),
    .Y_W      (YW),
    .WIN_X0   (WX0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .valid        (valid),
    .ch_enable    (ch_enable),
    .swap_req     (swap_req),
    .swap_ack     (swap_ack),
    .buf_sel      (buf_sel),
    .read_address (read_address),
    .read_value   (read_value),
    .valid_pixel  (valid_pixel),
    .r            (r),
    .g            (g),
    .b            (b)
  );

  // Synchronous sample RAM: data one cycle after address.
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++)
      read_value[c*SW +: SW] <= SW'(mem[read_address[AW]][c][read_address[AW-1:0]]);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_bank(input int bk);
    int mode, lvl, a, s;
    mode = $urandom_range(0, 2);
    lvl  = $urandom_range(0, 15);
    a    = $urandom_range(0, 15);
    s    = $urandom_range(1, NCOL-1);
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NCOL; k++) begin
        if (mode == 0)      mem[bk][c][k] = lvl;
        else if (mode == 1) mem[bk][c][k] = $urandom_range(0, 15);
        else                mem[bk][c][k] = (c == 0) ? ((k < s) ? a : lvl) : $urandom_range(0, 15);
      end
  endtask

  // Segment from the left-neighbour column's sample to this column's; the
  // first column of the window has no neighbour and draws a single dot.
  function automatic logic [24:0] model_pix(input int px, input int py, input bit v,
                                            input logic [NCH-1:0] en, input int bk);
    int col, ty, cur, prv, lo, hi;
    if (!(v && px >= WX0 && px < WX0 + WINW && py < WINH)) return 25'h0;
    col = (px - WX0) / 2;
    ty  = py / 2;
    for (int c = 0; c < NCH; c++) begin
      cur = mem[bk][c][col];
      prv = (col == 0) ? cur : mem[bk][c][col-1];
      lo  = (prv < cur) ? prv : cur;
      hi  = (prv < cur) ? cur : prv;
      if (en[c] && ty >= lo && ty <= hi) return {1'b1, col_tab[c]};
    end
    return {1'b1, 24'h000000};
  endfunction

  initial begin
    int          hold_target, acks_seen, col_hold, req_row;
    bit          exp_sel, exp_ack, n_sel, n_ack, pend_ok, pend_skip, skip_row;
    bit          prev_drop, drop, v, rst_now, fs, in_w, raise;
    logic [24:0] pend, e;

    col_tab[0] = 24'hFFFFFF;
    col_tab[1] = 24'hFF0000;
    col_tab[2] = 24'h00FF00;
    for (int k = 0; k < NCOL; k++) begin
      mem[0][0][k] = 5;
      mem[0][1][k] = 5;
      mem[0][2][k] = $urandom_range(0, 15);
    end
    fill_bank(1);

    reset = 1'b1; valid = 1'b0; x = '0; y = '0; ch_enable = '0; swap_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_rgb", 32'({r, g, b}), 32'h0);
    check_eq("reset_vp", 32'(valid_pixel), 32'h0);
    check_eq("reset_ack", 32'(swap_ack), 32'h0);
    check_eq("reset_sel", 32'(buf_sel), 32'h0);
    reset = 1'b0;

    exp_sel = 0; exp_ack = 0; col_hold = 0; pend_ok = 0; pend_skip = 0;
    skip_row = 0; prev_drop = 0; pend = '0; hold_target = 1; acks_seen = 0;

    for (int f = 0; f < NFR; f++) begin
      raise   = (f == 1) || (f == 2) || (f == 3) || (f == 6);
      req_row = (f == 2) ? 20 : $urandom_range(4, 28);
      for (int py = 0; py < FH; py++) begin
        for (int px = 0; px < FW; px++) begin
          rst_now = (f == 2 && py == 10 && px == 25);
          if (px == 0) begin
            ch_enable = NCH'($urandom_range(0, 7));
            skip_row  = 0;
            prev_drop = 0;
          end
          if (py == FH - 1 && px == 0) fill_bank(exp_sel ? 0 : 1);
          v    = (px < VW && py < VH);
          drop = v && px > WX0 && !prev_drop && ($urandom_range(0, 19) == 0);
          v    = v && !drop;
          prev_drop = drop;
          if (raise && py == req_row && px == 20) begin
            swap_req    = 1'b1;
            acks_seen   = 0;
            hold_target = (f == 3) ? 2 : 1;
          end
          x = XW'(px); y = YW'(py); valid = v; reset = rst_now;
          in_w = v && px >= WX0 && px < WX0 + WINW && py < WINH;
          #1;
          check_eq("addr", 32'(read_address),
                   32'({exp_sel, AW'(in_w ? (px - WX0) / 2 : col_hold)}));
          fs = v && px == 0 && py == 0;
          e  = model_pix(px, py, v, ch_enable, exp_sel ? 1 : 0);
          if (rst_now) begin
            n_sel = 0; n_ack = 0; col_hold = 0;
          end else begin
            n_ack = fs && swap_req && !exp_ack;
            n_sel = exp_sel ^ n_ack;
            if (in_w) col_hold = (px - WX0) / 2;
          end
          @(posedge clk);
          #1;
          exp_sel = n_sel;
          exp_ack = n_ack;
          check_eq("swap_ack", 32'(swap_ack), 32'(exp_ack));
          check_eq("buf_sel", 32'(buf_sel), 32'(exp_sel));
          if (rst_now) begin
            check_eq("midrst_rgb", 32'({r, g, b}), 32'h0);
            check_eq("midrst_vp", 32'(valid_pixel), 32'h0);
            pend      = '0;
            pend_skip = 0;
            skip_row  = 1;
            swap_req  = 1'b0;
          end else begin
            if (pend_ok) begin
              check_eq("valid_pixel", 32'(valid_pixel), 32'(pend[24]));
              if (!pend_skip) check_eq("rgb", 32'({r, g, b}), 32'(pend[23:0]));
            end
            pend      = e;
            pend_skip = skip_row;
          end
          pend_ok = 1;
          reset   = 1'b0;
          if (exp_ack && swap_req) begin
            acks_seen++;
            if (acks_seen >= hold_target) swap_req = 1'b0;
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
